// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU operations until both
// operands are valid, snoops the common data bus for missing operands, and
// issues the oldest ready operation into a stallable output register.
module alu_rs #(
    parameter int N_ENTRIES = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,

    input  logic             dispatch_valid_in,
    output logic             dispatch_ready_out,
    input  logic [3:0]       dispatch_aluFunc_in,
    input  logic [31:0]      dispatch_rval1_in,
    input  logic [31:0]      dispatch_rval2_in,
    input  logic             dispatch_rdy1_in,
    input  logic             dispatch_rdy2_in,
    input  logic [TAG_W-1:0] dispatch_tag1_in,
    input  logic [TAG_W-1:0] dispatch_tag2_in,
    input  logic [TAG_W-1:0] dispatch_dest_tag_in,

    input  logic             cdb_valid_in,
    input  logic [TAG_W-1:0] cdb_tag_in,
    input  logic [31:0]      cdb_data_in,

    input  logic             flush_in,

    output logic             issue_valid_out,
    input  logic             issue_ready_in,
    output logic [3:0]       issue_aluFunc_out,
    output logic [31:0]      issue_rval1_out,
    output logic [31:0]      issue_rval2_out,
    output logic [TAG_W-1:0] issue_dest_tag_out
);

    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    // Entry storage. age[i] has bit j set when entry j was dispatched before
    // entry i and is still held; this relative-age matrix never wraps, so
    // ordering stays correct however dispatches and frees interleave.
    logic [N_ENTRIES-1:0] valid;
    logic [3:0]           alu_func [N_ENTRIES];
    logic [N_ENTRIES-1:0] rdy1;
    logic [N_ENTRIES-1:0] rdy2;
    logic [TAG_W-1:0]     tag1     [N_ENTRIES];
    logic [TAG_W-1:0]     tag2     [N_ENTRIES];
    logic [31:0]          val1     [N_ENTRIES];
    logic [31:0]          val2     [N_ENTRIES];
    logic [TAG_W-1:0]     dest_tag [N_ENTRIES];
    logic [N_ENTRIES-1:0] age      [N_ENTRIES];

    logic [N_ENTRIES-1:0] ready;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 issue_load;
    logic                 dispatch_fire;
    logic [N_ENTRIES-1:0] keep_mask;
    logic                 disp_rdy1;
    logic                 disp_rdy2;
    logic [31:0]          disp_val1;
    logic [31:0]          disp_val2;

    assign ready = valid & rdy1 & rdy2;

    // Pick the ready entry that no other ready entry is older than.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (!sel_found && ready[i] && ((age[i] & ready) == '0)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest-indexed invalid entry receives the next dispatch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (!free_found && !valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign dispatch_ready_out = free_found;
    assign dispatch_fire      = dispatch_valid_in && dispatch_ready_out && !flush_in;
    assign issue_load         = (!issue_valid_out || issue_ready_in) && sel_found;

    // Entries that survive this edge; a new dispatch is younger than all of them.
    always_comb begin
        keep_mask = valid;
        if (issue_load) begin
            keep_mask[sel_idx] = 1'b0;
        end
    end

    // Same-cycle CDB bypass for operands arriving at dispatch.
    always_comb begin
        disp_rdy1 = dispatch_rdy1_in;
        disp_val1 = dispatch_rval1_in;
        disp_rdy2 = dispatch_rdy2_in;
        disp_val2 = dispatch_rval2_in;
        if (!dispatch_rdy1_in && cdb_valid_in && (cdb_tag_in == dispatch_tag1_in)) begin
            disp_rdy1 = 1'b1;
            disp_val1 = cdb_data_in;
        end
        if (!dispatch_rdy2_in && cdb_valid_in && (cdb_tag_in == dispatch_tag2_in)) begin
            disp_rdy2 = 1'b1;
            disp_val2 = cdb_data_in;
        end
    end

    // Entry state: free on issue, wake on CDB, write on dispatch; flush and
    // reset drop everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                age[i] <= '0;
            end
        end else if (flush_in) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (issue_load && (sel_idx == IDX_W'(i))) begin
                    valid[i] <= 1'b0;
                end
                if (valid[i] && !rdy1[i] && cdb_valid_in && (cdb_tag_in == tag1[i])) begin
                    rdy1[i] <= 1'b1;
                    val1[i] <= cdb_data_in;
                end
                if (valid[i] && !rdy2[i] && cdb_valid_in && (cdb_tag_in == tag2[i])) begin
                    rdy2[i] <= 1'b1;
                    val2[i] <= cdb_data_in;
                end
            end
            if (dispatch_fire) begin
                valid[free_idx]    <= 1'b1;
                alu_func[free_idx] <= dispatch_aluFunc_in;
                rdy1[free_idx]     <= disp_rdy1;
                val1[free_idx]     <= disp_val1;
                tag1[free_idx]     <= dispatch_tag1_in;
                rdy2[free_idx]     <= disp_rdy2;
                val2[free_idx]     <= disp_val2;
                tag2[free_idx]     <= dispatch_tag2_in;
                dest_tag[free_idx] <= dispatch_dest_tag_in;
                age[free_idx]      <= keep_mask;
                for (int i = 0; i < N_ENTRIES; i++) begin
                    if (free_idx != IDX_W'(i)) begin
                        age[i][free_idx] <= 1'b0;
                    end
                end
            end
        end
    end

    // Issue register: load the selected entry when empty or being consumed,
    // otherwise hold while stalled.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            issue_valid_out    <= 1'b0;
            issue_aluFunc_out  <= '0;
            issue_rval1_out    <= '0;
            issue_rval2_out    <= '0;
            issue_dest_tag_out <= '0;
        end else if (flush_in) begin
            issue_valid_out <= 1'b0;
        end else if (issue_load) begin
            issue_valid_out    <= 1'b1;
            issue_aluFunc_out  <= alu_func[sel_idx];
            issue_rval1_out    <= val1[sel_idx];
            issue_rval2_out    <= val2[sel_idx];
            issue_dest_tag_out <= dest_tag[sel_idx];
        end else if (issue_ready_in) begin
            issue_valid_out <= 1'b0;
        end
    end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 4: number of reservation-station entries; legal values 2..8.
REQ-002 SHALL have parameter TAG_W, default 4: width of producer tags.
REQ-003 clk_in  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 dispatch_valid_in  input  1  a new ALU operation is offered.
REQ-006 dispatch_ready_out  output  1  the station can accept a dispatch this cycle.
REQ-007 dispatch_aluFunc_in  input  4  ALU function code, using the shared AluFunc encoding.
REQ-008 dispatch_rval1_in / dispatch_rval2_in  input  32 each  operand values; meaningful only when the matching rdy bit is 1.
REQ-009 dispatch_rdy1_in / dispatch_rdy2_in  input  1 each  the operand value is already valid.
REQ-010 dispatch_tag1_in / dispatch_tag2_in  input  TAG_W each  producer tag awaited when the matching rdy bit is 0.
REQ-011 dispatch_dest_tag_in  input  TAG_W  tag that the result will carry.
REQ-012 cdb_valid_in, cdb_tag_in[TAG_W], cdb_data_in[32]  input  common data bus broadcast.
REQ-013 flush_in  input  1  discard all held operations.
REQ-014 issue_valid_out  output  1  an operation is presented to the ALU.
REQ-015 issue_ready_in  input  1  the ALU stage consumes the operation this cycle.
REQ-016 issue_aluFunc_out[4], issue_rval1_out[32], issue_rval2_out[32], issue_dest_tag_out[TAG_W]  output  the issued operation.

Function
REQ-017 Each entry SHALL hold: valid, aluFunc, two operands each as {rdy, tag, value}, dest tag, and an age.
REQ-018 dispatch_ready_out SHALL be 1 iff at least one entry is invalid, computed from registered state only; an entry freed in the same cycle does not count.
REQ-019 A dispatch is accepted iff dispatch_valid_in && dispatch_ready_out && !flush_in; it is written into the lowest-indexed invalid entry.
REQ-020 While an entry is valid, any operand with rdy=0 whose tag equals cdb_tag_in while cdb_valid_in=1 SHALL capture cdb_data_in and set rdy=1 at that edge.
REQ-021 At dispatch, an operand with rdy_in=0 whose tag matches a same-cycle CDB broadcast SHALL be stored with rdy=1 and the CDB data.
REQ-022 An entry is ready when it is valid and both of its operand rdy bits are 1, evaluated on registered state.
REQ-023 Selection SHALL pick the oldest ready entry by dispatch order, and SHALL NOT use index order to break ties.
REQ-024 The issue output register SHALL load when (!issue_valid_out || issue_ready_in) and a ready entry exists.
  - On load, the selected entry is freed at the same edge.
  - If no entry is ready, issue_valid_out goes to 0 after the consumption.
REQ-025 While issue_valid_out && !issue_ready_in, all issue_* outputs SHALL hold stable.
REQ-026 Latency: a dispatch with both operands ready at edge t SHALL appear on issue_valid_out at edge t+1 at the earliest. An operand woken by the CDB at edge t allows issue at edge t+1.
REQ-027 flush_in SHALL, at the edge, invalidate every entry and clear issue_valid_out. Flush overrides a same-cycle dispatch, CDB capture and issue.
REQ-028 A CDB broadcast whose tag matches no waiting operand SHALL have no effect. A single broadcast SHALL wake every matching operand in every entry.
REQ-029 Age ordering SHALL remain correct across arbitrary interleavings of dispatch and free, with no wrap-around ordering error.

Reset
REQ-030 On rst_in=1 at an edge, the block SHALL invalidate all entries, clear all ages, and drive issue_valid_out=0 and the issue_* data outputs to 0.
  - dispatch_ready_out reads 1 from the following cycle.
  - Reset overrides flush, dispatch, CDB and issue.
REQ-031 Reset asserted mid-operation, including while an issue is stalled, SHALL discard that operation with no later appearance on the outputs.

Verification
REQ-032 Dispatch Add, rval1=5 rdy, rval2=7 rdy, dest=3, issue_ready_in=1 -> next cycle issue_valid_out=1, aluFunc=Add, operands 5/7, dest 3; the entry is freed.
REQ-033 Dispatch Sub with op1 waiting on tag 2 (op2=1 rdy), then CDB tag 2 data 0x10 two cycles later -> issue Sub 0x10/1 one cycle after the broadcast, not earlier.
REQ-034 Fill all 4 entries with op1 waiting on tag 9 -> dispatch_ready_out=0. Then a single CDB for tag 9 -> four issues in dispatch order on consecutive cycles. dispatch_ready_out returns to 1 the cycle after the first free.
REQ-035 Hold issue_ready_in=0 for 3 cycles with a valid issue -> issue_* outputs stable throughout, and no entry is freed. Then release -> the next oldest ready entry issues on the following cycle.
REQ-036 Dispatch plus matching CDB in the same cycle (op2 tag 5, CDB tag 5, data 0xABCD) -> the entry issues next cycle with rval2=0xABCD.
REQ-037 Flush with 3 entries valid and a stalled issue -> next cycle issue_valid_out=0 and dispatch_ready_out=1, and no flushed operation ever issues. Repeat the same case with rst_in instead of flush_in -> same outcome.
